// File: rtl/dat_chunk_pkg.sv
// Shared types for the two-bank nonzero-data chunk buffer controller.
`ifndef MEM_SIZE
`define MEM_SIZE 64
`endif
`ifndef COMPUTE_UNIT_NUM
`define COMPUTE_UNIT_NUM 8
`endif

package dat_chunk_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2,
    READING = 2'd3
  } bank_state_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } rd_fsm_e;

  localparam int AW = $clog2(`MEM_SIZE) + 1;

  typedef logic [AW-1:0] addr_t;

endpackage

// File: rtl/dat_chunk_addr_gen.sv
// Per-lane 1-based read addresses, lane valid mask and last flag for one beat; purely combinational.
module dat_chunk_addr_gen
  import dat_chunk_pkg::*;
#(
  parameter int CU_NUM = `COMPUTE_UNIT_NUM
) (
  input  logic [AW:0]          base,
  input  addr_t                cnt,
  output logic [CU_NUM*AW-1:0] addr,
  output logic [CU_NUM-1:0]    lane_vld,
  output logic                 last
);

  logic [AW+1:0] sum;

  always_comb begin
    addr     = '0;
    lane_vld = '0;
    sum      = '0;
    for (int j = 0; j < CU_NUM; j++) begin
      sum                 = {1'b0, base} + (AW+2)'(j);
      lane_vld[j]         = (sum <= {2'b00, cnt});
      addr[j*AW +: AW]    = lane_vld[j] ? sum[AW-1:0] : addr_t'(1);
    end
    // Extra headroom bit keeps base+CU_NUM from wrapping near MEM_SIZE.
    last = (({1'b0, base} + (AW+2)'(CU_NUM)) > {2'b00, cnt});
  end

endmodule

// File: rtl/dat_chunk_pingpong_ctrl.sv
// Ping-pong bank controller: fill_done to first rd_vld is 2 cycles; beats hold while rd_vld_o && !rd_rdy_i.
// DAT_CHUNK_PERF_CNT_EN adds saturating stall/chunk counters; otherwise perf outputs are 0.
module dat_chunk_pingpong_ctrl
  import dat_chunk_pkg::*;
#(
  parameter int MEM_SIZE = `MEM_SIZE,
  parameter int CU_NUM   = `COMPUTE_UNIT_NUM
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 fill_req_i,
  output logic                 fill_gnt_o,
  output logic                 fill_sel_o,
  input  logic                 fill_done_i,
  input  logic [AW-1:0]        fill_cnt_i,
  output logic                 rd_sel_o,
  output logic [CU_NUM*AW-1:0] rd_addr_o,
  output logic [CU_NUM-1:0]    rd_lane_vld_o,
  output logic                 rd_vld_o,
  input  logic                 rd_rdy_i,
  output logic                 rd_last_o,
  output logic [1:0]           bank_full_o,
  output logic [31:0]          perf_stall_o,
  output logic [31:0]          perf_chunk_o
);

  localparam logic [AW:0]          STEP     = (AW+1)'(CU_NUM);
  localparam logic [AW:0]          BASE_ONE = (AW+1)'(1);
  localparam logic [CU_NUM*AW-1:0] ADDR_ONE = {CU_NUM{addr_t'(1)}};

  bank_state_e bank_q [2];
  bank_state_e bank_d [2];
  addr_t       cnt_q  [2];
  addr_t       fill_cnt_sat;
  logic        fill_sel_q;
  logic        rst_q;
  logic        filling;
  logic        accept;

  rd_fsm_e     state_q, state_d;
  logic        start, chain, finish;
  logic        rd_sel_q, rd_sel_d;
  logic [AW:0] base_q, base_d;
  logic        vld_d;
  logic        load;

  logic [CU_NUM*AW-1:0] gen_addr;
  logic [CU_NUM-1:0]    gen_vld;
  logic                 gen_last;

  assign filling      = (bank_q[0] == FILLING) || (bank_q[1] == FILLING);
  // Grant only from registered state, so a bank freed on this edge is granted at the earliest next edge.
  assign fill_gnt_o   = (bank_q[fill_sel_q] == EMPTY) && !filling && !rst_q;
  assign fill_sel_o   = fill_sel_q;
  assign fill_cnt_sat = (fill_cnt_i > addr_t'(MEM_SIZE)) ? addr_t'(MEM_SIZE) : fill_cnt_i;
  assign accept       = rd_vld_o && rd_rdy_i;
  assign rd_sel_o     = rd_sel_q;

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_full_o[b] = (bank_q[b] == FULL) || (bank_q[b] == READING);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    chain   = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bank_q[rd_sel_q] == FULL) begin
          state_d = RUN;
          start   = 1'b1;
        end
      end
      RUN: begin
        if (accept && rd_last_o) begin
          finish = 1'b1;
          if (bank_q[~rd_sel_q] == FULL) chain   = 1'b1;
          else                           state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_sel_d = rd_sel_q;
    base_d   = base_q;
    vld_d    = rd_vld_o;
    load     = 1'b0;
    if (start) begin
      base_d = BASE_ONE;
      vld_d  = 1'b1;
      load   = 1'b1;
    end else if (finish) begin
      rd_sel_d = ~rd_sel_q;
      base_d   = BASE_ONE;
      vld_d    = chain;
      load     = 1'b1;
    end else if (accept) begin
      base_d = base_q + STEP;
      load   = 1'b1;
    end
  end

  always_comb begin
    bank_d = bank_q;
    if (fill_req_i && fill_gnt_o) bank_d[fill_sel_q] = FILLING;
    if (fill_done_i && filling)   bank_d[fill_sel_q] = FULL;
    if (start)                    bank_d[rd_sel_q]   = READING;
    if (finish)                   bank_d[rd_sel_q]   = EMPTY;
    if (chain)                    bank_d[~rd_sel_q]  = READING;
  end

  dat_chunk_addr_gen #(.CU_NUM(CU_NUM)) u_addr_gen (
    .base     (base_d),
    .cnt      (cnt_q[rd_sel_d]),
    .addr     (gen_addr),
    .lane_vld (gen_vld),
    .last     (gen_last)
  );

  always_ff @(posedge clk_i) begin
    rst_q <= rst_i;
    if (rst_i) begin
      bank_q[0]  <= EMPTY;
      bank_q[1]  <= EMPTY;
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
      fill_sel_q <= 1'b0;
    end else begin
      bank_q <= bank_d;
      if (fill_done_i && filling) begin
        cnt_q[fill_sel_q] <= fill_cnt_sat;
        fill_sel_q        <= ~fill_sel_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_sel_q      <= 1'b0;
      base_q        <= BASE_ONE;
      rd_vld_o      <= 1'b0;
      rd_last_o     <= 1'b0;
      rd_lane_vld_o <= '0;
      rd_addr_o     <= ADDR_ONE;
    end else begin
      rd_sel_q <= rd_sel_d;
      base_q   <= base_d;
      rd_vld_o <= vld_d;
      if (load) begin
        rd_last_o     <= vld_d && gen_last;
        rd_lane_vld_o <= vld_d ? gen_vld : '0;
        rd_addr_o     <= vld_d ? gen_addr : ADDR_ONE;
      end
    end
  end

`ifdef DAT_CHUNK_PERF_CNT_EN
  logic [31:0] stall_q, chunk_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
      chunk_q <= '0;
    end else begin
      if (rd_vld_o && !rd_rdy_i && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      if (finish && (chunk_q != '1))                chunk_q <= chunk_q + 32'd1;
    end
  end

  assign perf_stall_o = stall_q;
  assign perf_chunk_o = chunk_q;
`else
  assign perf_stall_o = '0;
  assign perf_chunk_o = '0;
`endif

endmodule

// File: tb/tb_dat_chunk_pingpong_ctrl.sv
// Directed bench for dat_chunk_pingpong_ctrl with MEM_SIZE=64, CU_NUM=8 (AW=7).
module tb_dat_chunk_pingpong_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fill_req = 1'b0;
  logic        fill_gnt;
  logic        fill_sel;
  logic        fill_done = 1'b0;
  logic [6:0]  fill_cnt = '0;
  logic        rd_sel;
  logic [55:0] rd_addr;
  logic [7:0]  rd_lane_vld;
  logic        rd_vld;
  logic        rd_rdy = 1'b1;
  logic        rd_last;
  logic [1:0]  bank_full;
  logic [31:0] perf_stall;
  logic [31:0] perf_chunk;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dat_chunk_pingpong_ctrl #(.MEM_SIZE(64), .CU_NUM(8)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .fill_req_i    (fill_req),
    .fill_gnt_o    (fill_gnt),
    .fill_sel_o    (fill_sel),
    .fill_done_i   (fill_done),
    .fill_cnt_i    (fill_cnt),
    .rd_sel_o      (rd_sel),
    .rd_addr_o     (rd_addr),
    .rd_lane_vld_o (rd_lane_vld),
    .rd_vld_o      (rd_vld),
    .rd_rdy_i      (rd_rdy),
    .rd_last_o     (rd_last),
    .bank_full_o   (bank_full),
    .perf_stall_o  (perf_stall),
    .perf_chunk_o  (perf_chunk)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [55:0] bexp(input int base, input int cnt);
    logic [55:0] v;
    v = '0;
    for (int j = 0; j < 8; j++) v[j*7 +: 7] = (base + j <= cnt) ? 7'(base + j) : 7'd1;
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // Returns after the edge that sampled fill_done.
  task automatic do_fill(input logic [6:0] c);
    int n;
    n = 0;
    fill_req = 1'b1;
    while (!fill_gnt && n < 20) begin
      step();
      n++;
    end
    chk("fill_gnt_wait", fill_gnt, 1'b1);
    step();
    fill_req  = 1'b0;
    fill_done = 1'b1;
    fill_cnt  = c;
    step();
    fill_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    step();
    step();
    chk("rst_vld", rd_vld, 1'b0);
    chk("rst_last", rd_last, 1'b0);
    chk("rst_lane", rd_lane_vld, 8'h00);
    chk("rst_addr", rd_addr, bexp(1, 0));
    chk("rst_full", bank_full, 2'b00);
    chk("rst_fsel", fill_sel, 1'b0);
    chk("rst_rsel", rd_sel, 1'b0);
    chk("rst_gnt", fill_gnt, 1'b0);
    rst = 1'b0;
    step();
    chk("gnt_after_rst", fill_gnt, 1'b1);

    // cnt=20: three beats, two-cycle latency from fill_done
    rd_rdy   = 1'b1;
    fill_req = 1'b1;
    step();
    chk("gnt_while_filling", fill_gnt, 1'b0);
    fill_req  = 1'b0;
    fill_done = 1'b1;
    fill_cnt  = 7'd20;
    step();
    fill_done = 1'b0;
    chk("t1_vld_n", rd_vld, 1'b0);
    chk("t1_full_n", bank_full, 2'b01);
    chk("t1_fsel", fill_sel, 1'b1);
    step();
    chk("t1_vld_n1", rd_vld, 1'b1);
    chk("t1_b0_addr", rd_addr, bexp(1, 20));
    chk("t1_b0_lane", rd_lane_vld, 8'hFF);
    chk("t1_b0_last", rd_last, 1'b0);
    chk("t1_rsel", rd_sel, 1'b0);
    step();
    chk("t1_b1_addr", rd_addr, bexp(9, 20));
    chk("t1_b1_last", rd_last, 1'b0);
    step();
    chk("t1_b2_addr", rd_addr, bexp(17, 20));
    chk("t1_b2_lane", rd_lane_vld, 8'h0F);
    chk("t1_b2_last", rd_last, 1'b1);
    step();
    chk("t1_end_vld", rd_vld, 1'b0);
    chk("t1_end_rsel", rd_sel, 1'b1);
    chk("t1_end_full", bank_full, 2'b00);

    // Both banks loaded before reading: no bubble on bank switch
    do_reset();
    rd_rdy = 1'b0;
    do_fill(7'd8);
    do_fill(7'd16);
    chk("t2_full", bank_full, 2'b11);
    chk("t2_gnt", fill_gnt, 1'b0);
    chk("t2_b0_addr", rd_addr, bexp(1, 8));
    chk("t2_b0_last", rd_last, 1'b1);
    chk("t2_b0_rsel", rd_sel, 1'b0);
    rd_rdy = 1'b1;
    step();
    chk("t2_b1_vld", rd_vld, 1'b1);
    chk("t2_b1_rsel", rd_sel, 1'b1);
    chk("t2_b1_addr", rd_addr, bexp(1, 16));
    chk("t2_b1_last", rd_last, 1'b0);
    step();
    chk("t2_b2_addr", rd_addr, bexp(9, 16));
    chk("t2_b2_last", rd_last, 1'b1);
    step();
    chk("t2_end_vld", rd_vld, 1'b0);
    chk("t2_end_rsel", rd_sel, 1'b0);

    // Five stall cycles mid-chunk
    do_reset();
    rd_rdy = 1'b1;
    do_fill(7'd24);
    step();
    step();
    chk("t3_pre_addr", rd_addr, bexp(9, 24));
    rd_rdy = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("t3_hold_vld", rd_vld, 1'b1);
    chk("t3_hold_addr", rd_addr, bexp(9, 24));
    chk("t3_hold_lane", rd_lane_vld, 8'hFF);
`ifdef DAT_CHUNK_PERF_CNT_EN
    chk("t3_perf_stall", perf_stall, 32'd5);
`else
    chk("t3_perf_stall", perf_stall, 32'd0);
`endif
    rd_rdy = 1'b1;
    step();
    chk("t3_b2_addr", rd_addr, bexp(17, 24));
    chk("t3_b2_last", rd_last, 1'b1);
    step();
    chk("t3_end_vld", rd_vld, 1'b0);
`ifdef DAT_CHUNK_PERF_CNT_EN
    chk("t3_perf_chunk", perf_chunk, 32'd1);
`else
    chk("t3_perf_chunk", perf_chunk, 32'd0);
`endif

    // Empty chunk
    do_reset();
    rd_rdy = 1'b0;
    do_fill(7'd0);
    step();
    chk("t4_vld", rd_vld, 1'b1);
    chk("t4_lane", rd_lane_vld, 8'h00);
    chk("t4_addr", rd_addr, bexp(1, 0));
    chk("t4_last", rd_last, 1'b1);
    rd_rdy = 1'b1;
    step();
    chk("t4_end_vld", rd_vld, 1'b0);
    chk("t4_end_full", bank_full, 2'b00);

    // Oversized count saturates to MEM_SIZE
    do_reset();
    rd_rdy = 1'b1;
    do_fill(7'd69);
    step();
    for (int b = 0; b < 8; b++) begin
      chk("t5_addr", rd_addr, bexp(1 + 8 * b, 64));
      chk("t5_last", rd_last, b == 7);
      step();
    end
    chk("t5_end_vld", rd_vld, 1'b0);

    // Reset during a read beat
    do_reset();
    rd_rdy = 1'b0;
    do_fill(7'd20);
    step();
    chk("t6_vld", rd_vld, 1'b1);
    rst = 1'b1;
    step();
    chk("t6_rst_vld", rd_vld, 1'b0);
    chk("t6_rst_full", bank_full, 2'b00);
    chk("t6_rst_rsel", rd_sel, 1'b0);
    rst    = 1'b0;
    rd_rdy = 1'b1;
    step();
    do_fill(7'd4);
    step();
    chk("t6_post_vld", rd_vld, 1'b1);
    chk("t6_post_addr", rd_addr, bexp(1, 4));
    chk("t6_post_lane", rd_lane_vld, 8'h0F);
    chk("t6_post_last", rd_last, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
